pipeline_hazard_unit: RTL

- Parametrised hazard-control block for the 5-stage IF/ID/EX/MEM/WB pipeline processor; replaces the current hazard-free operation.
- Keeps its own shadow pipeline of in-flight destination registers for the EX, MEM and WB slots.
- From that state it generates:
  - PC / IF-ID enables for stalls
  - IF-ID and ID-EX flushes on taken jumps
  - operand-forwarding selects for the three EX operands (RD1, RD2, RD3)
  - saturating stall and flush performance counters

---
 rtl/pipeline_hazard_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_unit.sv
// Hazard control for the 5-stage pipeline: tracks in-flight destinations in
// EX/MEM/WB and produces stall, flush, operand-forward and counter outputs.
module pipeline_hazard_unit #(
   parameter int REG_AW         = 4,
   parameter bit ENABLE_FWD     = 1'b1,
   parameter bit WB_BYPASS      = 1'b1,
   parameter int LOAD_USE_STALL = 1,
   parameter bit R0_ZERO        = 1'b0,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rs3,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic              id_use3,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_pcsource,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [1:0]        fwd_c,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } slot_t;

   typedef struct packed {
      slot_t                  w;
      logic [2:0][REG_AW-1:0] rs;
      logic [2:0]             rdUse;
   } exSlot_t;

   exSlot_t exQ, exD;
   slot_t   memQ, wbQ;
   logic [CNT_W-1:0] stallCntQ, stallCntD, flushCntQ, flushCntD;

   logic [2:0][REG_AW-1:0] idSrc;
   logic [2:0]             idUse;
   logic                   loadUse, noFwdHazard, stall, jump;
   logic [2:0][1:0]        fwdSel;

   assign idSrc = {id_rs3, id_rs2, id_rs1};
   assign idUse = {id_use3, id_use2, id_use1};
   assign jump  = ex_pcsource;

   // A hardwired r0 is never a real producer, so it must not match.
   function automatic logic writerMatch(slot_t s, logic [REG_AW-1:0] src, logic srcUsed);
      return s.valid && s.regwrite && srcUsed && (s.rd == src) && !(R0_ZERO && (src == '0));
   endfunction

   always_comb begin
      loadUse     = 1'b0;
      noFwdHazard = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (writerMatch(exQ.w, idSrc[i], idUse[i]) && exQ.w.memread)
            loadUse = 1'b1;
         if ((LOAD_USE_STALL == 2) && writerMatch(memQ, idSrc[i], idUse[i]) && memQ.memread)
            loadUse = 1'b1;
         if (writerMatch(exQ.w, idSrc[i], idUse[i]) || writerMatch(memQ, idSrc[i], idUse[i]) ||
             (!WB_BYPASS && writerMatch(wbQ, idSrc[i], idUse[i])))
            noFwdHazard = 1'b1;
      end
      stall = id_valid && (loadUse || (!ENABLE_FWD && noFwdHazard));
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         fwdSel[i] = 2'd0;
         if (ENABLE_FWD) begin
            if (writerMatch(memQ, exQ.rs[i], exQ.rdUse[i]) && !memQ.memread)
               fwdSel[i] = 2'd1;
            else if (writerMatch(memQ, exQ.rs[i], exQ.rdUse[i]) && (LOAD_USE_STALL == 1))
               fwdSel[i] = 2'd3;
            else if (writerMatch(wbQ, exQ.rs[i], exQ.rdUse[i]) && !WB_BYPASS)
               fwdSel[i] = 2'd2;
         end
      end
   end

   // A taken jump wins over a stall: the wrong-path ID instruction is discarded anyway.
   assign pc_en      = jump || !stall;
   assign ifid_en    = jump || !stall;
   assign ifid_flush = jump;
   assign idex_flush = jump || stall;
   assign fwd_a      = fwdSel[0];
   assign fwd_b      = fwdSel[1];
   assign fwd_c      = fwdSel[2];
   assign stall_cnt  = stallCntQ;
   assign flush_cnt  = flushCntQ;

   always_comb begin
      exD = '0;
      if (!idex_flush) begin
         exD.w.valid    = id_valid;
         exD.w.rd       = id_rd;
         exD.w.regwrite = id_regwrite;
         exD.w.memread  = id_memread;
         exD.rs         = idSrc;
         exD.rdUse      = idUse;
      end
      stallCntD = stallCntQ;
      if (stall && !jump && (stallCntQ != {CNT_W{1'b1}}))
         stallCntD = stallCntQ + CNT_W'(1);
      flushCntD = flushCntQ;
      if (jump && (flushCntQ != {CNT_W{1'b1}}))
         flushCntD = flushCntQ + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exQ       <= '0;
         memQ      <= '0;
         wbQ       <= '0;
         stallCntQ <= '0;
         flushCntQ <= '0;
      end else begin
         exQ       <= exD;
         memQ      <= exQ.w;
         wbQ       <= memQ;
         stallCntQ <= stallCntD;
         flushCntQ <= flushCntD;
      end
   end

endmodule
